autocorr_seq: RTL and testbench

Frame-based autocorrelation sequencer for the LPC analysis path. It buffers one frame of 16-bit speech samples, then replays the frame through the 11-tap sample delay line (`shift_1x10`) once per lag. For each lag it drives the one-hot tap select, multiplies current × delayed sample, and accumulates R[0..10]. Results stream to the downstream Levinson–Durbin stage one lag at a time.

---
 rtl/lpc_pkg.sv | 19 +
 rtl/autocorr_frame_buf.sv | 27 ++
 rtl/autocorr_seq.sv | 154 +++++++++++++++
 tb/tb_autocorr_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared constants and state type for the LPC autocorrelation path.
package lpc_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int ORDER         = 10;
  localparam int TAP_W         = ORDER + 1;
  localparam int LAG_W         = 4;
  localparam int FRAME_LEN_DEF = 160;
  localparam int ACC_W_DEF     = 40;
  localparam int ACC_SHIFT_DEF = 6;
  localparam int PROD_W        = 2 * SAMPLE_W;
  localparam int OUT_W         = 32;

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/autocorr_frame_buf.sv
// One-frame sample store: synchronous write port, combinational read port.
module autocorr_frame_buf
  import lpc_pkg::*;
#(
  parameter int DEPTH = FRAME_LEN_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  // Contents need no reset: a frame is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/autocorr_seq.sv
// Frame autocorrelation sequencer: buffers a frame, replays it once per lag through the
// external delay line and streams R[0..ORDER]. Define AUTOCORR_SAT_EN to saturate the output.
module autocorr_seq
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ACC_SHIFT = ACC_SHIFT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic [SAMPLE_W-1:0] sr_din,
  output logic [TAP_W-1:0]    sr_tap,
  input  logic [SAMPLE_W-1:0] sr_dout,
  output logic                r_valid,
  output logic [LAG_W-1:0]    r_lag,
  output logic [OUT_W-1:0]    r_data,
  output logic                busy
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN + 2);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_CYC = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] EMIT_CYC  = CNT_W'(FRAME_LEN + 1);
  localparam logic [LAG_W-1:0] LAST_LAG  = LAG_W'(ORDER);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d;
  logic [LAG_W-1:0]         lag_q, lag_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                     wr_en;
  logic                     streaming;
  logic                     emitting;
  logic [SAMPLE_W-1:0]      buf_rd;
  logic signed [OUT_W-1:0]  acc_out;

  autocorr_frame_buf #(
    .DEPTH (FRAME_LEN)
  ) u_frame_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (s_data),
    .rd_idx_i  (IDX_W'(cyc_q)),
    .rd_data_o (buf_rd)
  );

  always_comb begin
    streaming = (state_q == CALC) && (cyc_q < DRAIN_CYC);
    emitting  = (state_q == CALC) && (cyc_q == EMIT_CYC);
    wr_en     = (state_q == LOAD) && s_valid;
  end

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == CALC);
  assign sr_din  = streaming ? buf_rd : '0;
  assign sr_tap  = streaming ? (TAP_W'(1) << lag_q) : TAP_W'(1);

  // Products before cycle k would pair with stale delay-line contents, so they are forced to zero.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    cyc_d    = cyc_q;
    lag_d    = lag_q;
    prod_d   = '0;
    acc_d    = acc_q;
    unique case (state_q)
      LOAD: begin
        if (wr_en) begin
          if (wr_idx_q == LAST_IDX) begin
            state_d  = CALC;
            wr_idx_d = '0;
            cyc_d    = '0;
            lag_d    = '0;
            acc_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      CALC: begin
        if (streaming && (cyc_q >= CNT_W'(lag_q))) begin
          prod_d = PROD_W'($signed(sr_din)) * PROD_W'($signed(sr_dout));
        end
        if (emitting) begin
          acc_d = '0;
          cyc_d = '0;
          if (lag_q == LAST_LAG) begin
            state_d = LOAD;
            lag_d   = '0;
          end else begin
            lag_d = lag_q + 1'b1;
          end
        end else begin
          acc_d = acc_q + ACC_W'(prod_q);
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

`ifdef AUTOCORR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(signed'(32'h7FFF_FFFF));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(signed'(32'h8000_0000));

  logic signed [ACC_W-1:0] acc_shifted;

  always_comb begin
    acc_shifted = acc_q >>> ACC_SHIFT;
    if (acc_shifted > SAT_MAX) begin
      acc_out = 32'sh7FFF_FFFF;
    end else if (acc_shifted < SAT_MIN) begin
      acc_out = 32'sh8000_0000;
    end else begin
      acc_out = acc_shifted[OUT_W-1:0];
    end
  end
`else
  // The low word of the arithmetic shift is just a slice of the accumulator.
  assign acc_out = acc_q[ACC_SHIFT +: OUT_W];
`endif

  assign r_valid = emitting;
  assign r_lag   = emitting ? lag_q : '0;
  assign r_data  = emitting ? acc_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      cyc_q    <= '0;
      lag_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      cyc_q    <= cyc_d;
      lag_q    <= lag_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_autocorr_seq.sv
// Self-checking bench for autocorr_seq with a behavioural 11-tap delay line alongside it.
module tb_autocorr_seq;

  localparam int FRAME    = 160;
  localparam int PASS_LEN = FRAME + 2;
  localparam int CALC_LEN = 11 * PASS_LEN;
  localparam int ABORT_AT = 700;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [15:0] sr_din;
  logic [10:0] sr_tap;
  logic [15:0] sr_dout;
  logic        r_valid;
  logic [3:0]  r_lag;
  logic [31:0] r_data;
  logic        busy;

  logic [15:0] dlQ [1:10];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              pattern;
    bit              gaps;
    bit              holdNext;
    int              startIdx;
    logic [10:0][31:0] expR;
  } vec_t;

  vec_t vecs [4];

  autocorr_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .sr_din  (sr_din),
    .sr_tap  (sr_tap),
    .sr_dout (sr_dout),
    .r_valid (r_valid),
    .r_lag   (r_lag),
    .r_data  (r_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay line: tap 0 is the current input, tap i is the input from i clocks earlier.
  always_ff @(posedge clk) begin
    dlQ[1] <= sr_din;
    for (int i = 2; i <= 10; i++) dlQ[i] <= dlQ[i-1];
  end

  always_comb begin
    sr_dout = '0;
    if (sr_tap[0]) sr_dout = sr_din;
    for (int i = 1; i <= 10; i++) if (sr_tap[i]) sr_dout = dlQ[i];
  end

  task automatic compareValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] sampleOf(input int pattern, input int i);
    case (pattern)
      0:       return 16'h0100;
      1:       return (i == 0) ? 16'h4000 : 16'h0000;
      2:       return (i % 2 == 0) ? 16'sd1000 : -16'sd1000;
      default: return 16'h7FFF;
    endcase
  endfunction

  task automatic checkResetState(input string tag);
    compareValue({tag, "_s_ready"}, s_ready, 1);
    compareValue({tag, "_busy"}, busy, 0);
    compareValue({tag, "_r_valid"}, r_valid, 0);
    compareValue({tag, "_r_lag"}, r_lag, 0);
    compareValue({tag, "_r_data"}, r_data, 0);
    compareValue({tag, "_sr_din"}, sr_din, 0);
    compareValue({tag, "_sr_tap"}, sr_tap, 11'h001);
  endtask

  // Leaves the last sample presented; it is taken on the following rising edge.
  task automatic applyStimulus(input int pattern, input int startIdx, input bit gaps);
    int i = startIdx;
    int attempts = 0;
    while (i < FRAME && attempts < 4000) begin
      @(negedge clk);
      attempts++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = sampleOf(pattern, i);
      end
      if (s_valid && s_ready) i++;
    end
    compareValue("loadSamples", i, FRAME);
  endtask

  task automatic checkOutput(input int v, input bit hold, input int stopAt, output int lagsSeen);
    int nextLag = 0;
    int busyCycles = 0;
    for (int j = 1; j <= stopAt; j++) begin
      @(negedge clk);
      if (j <= CALC_LEN && busy && !s_ready) busyCycles++;
      if (r_valid) begin
        if (nextLag <= 10) begin
          compareValue($sformatf("v%0d_lag%0d_idx", v, nextLag), r_lag, nextLag);
          compareValue($sformatf("v%0d_lag%0d_time", v, nextLag), j, (nextLag + 1) * PASS_LEN);
          compareValue($sformatf("v%0d_R%0d", v, nextLag), longint'($signed(r_data)),
                       longint'($signed(vecs[v].expR[nextLag])));
        end else begin
          compareValue($sformatf("v%0d_extraPulse", v), nextLag, 10);
        end
        nextLag++;
      end
      if (j == 1) begin
        s_valid = hold;
        if (hold) s_data = 16'h4000;
      end
    end
    if (stopAt > CALC_LEN) begin
      compareValue($sformatf("v%0d_busyCycles", v), busyCycles, CALC_LEN);
      compareValue($sformatf("v%0d_readyAfter", v), s_ready, 1);
      compareValue($sformatf("v%0d_idleAfter", v), busy, 0);
    end
    lagsSeen = nextLag;
  endtask

  initial begin
    int     seen;
    int     pulses;
    longint full;

    vecs[0].pattern = 0; vecs[0].gaps = 1; vecs[0].holdNext = 1; vecs[0].startIdx = 0;
    vecs[1].pattern = 1; vecs[1].gaps = 0; vecs[1].holdNext = 0; vecs[1].startIdx = 1;
    vecs[2].pattern = 2; vecs[2].gaps = 1; vecs[2].holdNext = 0; vecs[2].startIdx = 0;
    vecs[3].pattern = 3; vecs[3].gaps = 0; vecs[3].holdNext = 0; vecs[3].startIdx = 0;
    for (int k = 0; k <= 10; k++) begin
      vecs[0].expR[k] = 32'((160 - k) * 1024);
      vecs[1].expR[k] = (k == 0) ? 32'd4194304 : 32'd0;
      vecs[2].expR[k] = 32'(((k % 2) == 1 ? -1 : 1) * (160 - k) * 15625);
      full = (longint'(160 - k) * 64'sd1073676289) >>> 6;
`ifdef AUTOCORR_SAT_EN
      vecs[3].expR[k] = (full > 64'sd2147483647) ? 32'h7FFF_FFFF : full[31:0];
`else
      vecs[3].expR[k] = full[31:0];
`endif
    end
`ifdef AUTOCORR_SAT_EN
    vecs[3].expR[0] = 32'h7FFF_FFFF;
`else
    vecs[3].expR[0] = 32'(-1610776574);
`endif

    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      $display("[TB] frame pattern %0d", vecs[v].pattern);
      applyStimulus(vecs[v].pattern, vecs[v].startIdx, vecs[v].gaps);
      checkOutput(v, vecs[v].holdNext, CALC_LEN + 1, seen);
      compareValue($sformatf("v%0d_lagCount", v), seen, 11);
    end

    $display("[TB] reset during lag-4 pass");
    applyStimulus(2, 0, 0);
    checkOutput(2, 0, ABORT_AT, seen);
    compareValue("abort_lagsBefore", seen, 4);
    rst_n = 1'b0;
    #1;
    checkResetState("abort");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (r_valid || busy) pulses++;
    end
    compareValue("abort_noPulses", pulses, 0);

    applyStimulus(2, 0, 0);
    checkOutput(2, 0, CALC_LEN + 1, seen);
    compareValue("afterAbort_lagCount", seen, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
